// File: rtl/ysyx_22041207_booth_mul.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU), one digit per cycle.
// Ports: clk, rst (sync, active-high), mul_valid/mul_ready request handshake,
// flush abort, mul_signed {A signed, B signed}, multiplicand/multiplier operands,
// out_valid/out_ready result handshake, result_hi/result_lo full product.
// Optional macro YSYX_MUL_EARLY_OUT_EN: finish once all remaining digits are zero.
module ysyx_22041207_booth_mul #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    input  logic            out_ready,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int ITER = XLEN / 2 + 1;
    localparam int BW   = XLEN + 2;
    localparam int AW   = 2 * XLEN + 2;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] m_reg;
    logic [BW-1:0] b_reg;
    logic          guard;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic [AW-1:0] a_ext;
    logic [BW-1:0] b_ext;
    logic [2:0]    triplet;
    logic [AW-1:0] sel;
    logic [AW-1:0] acc_next;
    logic [BW-1:0] b_next;
    logic          last;
    logic          finish;
    logic          unused_acc;

    // Extension to XLEN+2 (and beyond for A) keeps unsigned full range exact.
    assign a_ext = {{(AW - XLEN){mul_signed[1] & multiplicand[XLEN-1]}},
                    multiplicand};
    assign b_ext = {{2{mul_signed[0] & multiplier[XLEN-1]}}, multiplier};

    assign triplet = {b_reg[1:0], guard};

    always_comb begin
        sel = '0;
        case (triplet)
            3'b001, 3'b010: sel = m_reg;
            3'b011:         sel = m_reg << 1;
            3'b100:         sel = -(m_reg << 1);
            3'b101, 3'b110: sel = -m_reg;
            default:        sel = '0;
        endcase
    end

    assign acc_next   = acc + sel;
    assign b_next     = {{2{b_reg[BW-1]}}, b_reg[BW-1:2]};
    assign last       = (cnt == CW'(ITER - 1));
    assign unused_acc = ^acc_next[AW-1:AW-2];

`ifdef YSYX_MUL_EARLY_OUT_EN
    // Remaining bits plus next guard all equal -> every later digit is 0.
    assign finish = last
                  | (&{b_next, b_reg[1]})
                  | ~(|{b_next, b_reg[1]});
`else
    assign finish = last;
`endif

    assign mul_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            m_reg     <= '0;
            b_reg     <= '0;
            guard     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mul_valid) begin
                        m_reg <= a_ext;
                        b_reg <= b_ext;
                        guard <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_next;
                    m_reg <= m_reg << 2;
                    b_reg <= b_next;
                    guard <= b_reg[1];
                    cnt   <= cnt + 1'b1;
                    if (finish) begin
                        result_hi <= acc_next[2*XLEN-1:XLEN];
                        result_lo <= acc_next[XLEN-1:0];
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_booth_mul.sv
// Self-checking bench for ysyx_22041207_booth_mul (XLEN=64): vector table
// plus back-pressure, flush, reset and early-out sequences.
module tb_ysyx_22041207_booth_mul;

    localparam int XLEN = 64;
    localparam int ITER = XLEN / 2 + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            mul_valid;
    logic            flush;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_ready;
    logic            mul_ready;
    logic            out_valid;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    int errors = 0;
    int checks = 0;

    ysyx_22041207_booth_mul #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_ready    (out_ready),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      mode;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] mode, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        @(negedge clk);
        chk("ready_before_req", 128'(mul_ready), 128'(1));
        mul_signed   = mode;
        multiplicand = a;
        multiplier   = b;
        mul_valid    = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [XLEN-1:0] hold_hi;
        logic [XLEN-1:0] hold_lo;

        vecs[0]  = '{2'b00, 64'd3, 64'd5, 64'd0, 64'd15};
        vecs[1]  = '{2'b11, '1, '1, 64'd0, 64'd1};
        vecs[2]  = '{2'b00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
        vecs[3]  = '{2'b10, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[4]  = '{2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'h4000_0000_0000_0000, 64'd0};
        vecs[5]  = '{2'b01, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[6]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[7]  = '{2'b00, 64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0};
        vecs[8]  = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'hC000_0000_0000_0000, 64'd0};
        vecs[9]  = '{2'b11, 64'd7, 64'd6, 64'd0, 64'd42};
        vecs[10] = '{2'b00, 64'h1234_5678, 64'h1_0000, 64'd0,
                     64'h1234_5678_0000};

        rst = 1'b1;
        mul_valid = 1'b0;
        flush = 1'b0;
        mul_signed = 2'b00;
        multiplicand = '0;
        multiplier = '0;
        out_ready = 1'b1;
        wait_edges(2);
        chk("rst_ready", 128'(mul_ready), 128'(1));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_hi", 128'(result_hi), 128'(0));
        chk("rst_lo", 128'(result_lo), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start(vecs[i].mode, vecs[i].a, vecs[i].b);
            chk("busy_ready", 128'(mul_ready), 128'(0));
            wait_valid(lat);
`ifdef YSYX_MUL_EARLY_OUT_EN
            chk("lat_bound", 128'(lat <= ITER && lat >= 1), 128'(1));
`else
            chk("latency", 128'(lat), 128'(ITER));
`endif
            chk($sformatf("v%0d_hi", i), 128'(result_hi), 128'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 128'(result_lo), 128'(vecs[i].lo));
            wait_edges(1);
            chk("idle_ready", 128'(mul_ready), 128'(1));
            chk("idle_valid", 128'(out_valid), 128'(0));
        end

        // Back-pressure: result held, new requests ignored.
        out_ready = 1'b0;
        start(2'b00, 64'd9, 64'd11);
        wait_valid(lat);
        chk("bp_lo", 128'(result_lo), 128'(99));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mul_valid = 1'b1;
            multiplicand = 64'd1000 + 64'(c);
            multiplier = 64'd3;
            @(posedge clk);
            #1;
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_ready", 128'(mul_ready), 128'(0));
            chk("bp_hold", 128'({result_hi, result_lo}), 128'(99));
        end
        @(negedge clk);
        mul_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 128'({mul_ready, out_valid}), 128'(2'b10));

        // Flush mid-BUSY beats a same-cycle request.
        start(2'b00, 64'd13, 64'd17);
        wait_edges(9);
        @(negedge clk);
        flush = 1'b1;
        mul_valid = 1'b1;
        multiplicand = 64'd5;
        multiplier = 64'd5;
        @(posedge clk);
        #1;
        flush = 1'b0;
        mul_valid = 1'b0;
        chk("fl_ready", 128'(mul_ready), 128'(1));
        chk("fl_valid", 128'(out_valid), 128'(0));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || !mul_ready) seen++;
        end
        chk("fl_quiet", 128'(seen), 128'(0));
        chk("fl_no_update", 128'(result_lo), 128'(99));
        start(2'b00, 64'd7, 64'd6);
        wait_valid(lat);
        chk("after_fl_lo", 128'(result_lo), 128'(42));
        wait_edges(1);

        // Flush in DONE drops the result even with out_ready high.
        out_ready = 1'b0;
        start(2'b00, 64'd4, 64'd4);
        wait_valid(lat);
        hold_hi = result_hi;
        hold_lo = result_lo;
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fld_state", 128'({mul_ready, out_valid}), 128'(2'b10));
        chk("fld_keep", 128'({result_hi, result_lo}), {hold_hi, hold_lo});
        chk("fld_lo", 128'(hold_lo), 128'(16));

        // Reset mid-BUSY.
        start(2'b11, 64'd123, 64'd456);
        wait_edges(5);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_ready", 128'(mul_ready), 128'(1));
        chk("mrst_valid", 128'(out_valid), 128'(0));
        chk("mrst_res", 128'({result_hi, result_lo}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

`ifdef YSYX_MUL_EARLY_OUT_EN
        start(2'b00, 64'd7, 64'd2);
        wait_valid(lat);
        chk("eo_lat2", 128'(lat), 128'(2));
        chk("eo_lo14", 128'({result_hi, result_lo}), 128'(14));
        wait_edges(1);
        start(2'b00, 64'd7, 64'd0);
        wait_valid(lat);
        chk("eo_lat1", 128'(lat), 128'(1));
        chk("eo_zero", 128'({result_hi, result_lo}), 128'(0));
        wait_edges(1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
